// File: rtl/diff_demo_pkg.sv
// Shared definitions for the write-back stream slice.
// Holds the write-back FSM state type, the default channel count, the
// partial-sum width and the partial-sum buffer depth.
package diff_demo_pkg;

  localparam int unsigned WB_CH_DEFAULT               = 6;
  localparam int unsigned PSUM_WIDTH                  = 16;
  localparam int unsigned FM_GUARD_GEN_PSUM_BUF_DEPTH = 16;

  typedef enum logic [2:0] {
    WB_IDLE,
    WB_FETCH,
    WB_LOAD,
    WB_EMIT,
    WB_DONE
  } wb_state_t;

endpackage

// File: rtl/wb_pick_first.sv
// Priority picker: returns the highest set index of an N-bit mask.
// Ports:
//   mask     in  N   candidate mask
//   idx_c    out IW  highest set index (0 when mask is empty)
//   found_c  out 1   mask has at least one bit set
module wb_pick_first #(
  parameter int unsigned N  = 6,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  mask,
  output logic [IW-1:0] idx_c,
  output logic          found_c
);

  // Ascending scan: the last hit is the highest index.
  always_comb begin
    idx_c   = '0;
    found_c = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (mask[i]) begin
        idx_c   = IW'(i);
        found_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/write_back_stream.sv
// Write-back stage: reads CH-channel partial-sum words, applies ReLU and
// width reduction, and streams the non-zero results as zero-skipped bytes
// plus one guard mask per address per pass. Dense mode runs one pass;
// differential mode runs an 8-bit pass then a packed 4-bit pass.
// Build option: WB_SATURATE_EN clamps ReLU results to 2^DW-1, otherwise
// they are truncated to the low DW bits.
// Ports:
//   clk, rst                       clock, async active-high reset
//   ctrl_valid/ctrl_ready          job request / idle handshake
//   ctrl_finish                    one-cycle job-done pulse
//   stop_addr_i, is_diff_i         last address (inclusive), diff mode
//   rd_en, addr_o, data_i          buffer read port (1-cycle latency)
//   data_o/_valid/_ready           output byte stream
//   guard_o/_valid/_ready          guard mask stream
module write_back_stream #(
  parameter int unsigned CH         = diff_demo_pkg::WB_CH_DEFAULT,
  parameter int unsigned PSUM_WIDTH = diff_demo_pkg::PSUM_WIDTH,
  parameter int unsigned DW         = 8,
  parameter int unsigned AW         = $clog2(diff_demo_pkg::FM_GUARD_GEN_PSUM_BUF_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ctrl_valid,
  output logic                     ctrl_ready,
  output logic                     ctrl_finish,
  input  logic [AW-1:0]            stop_addr_i,
  input  logic                     is_diff_i,
  output logic                     rd_en,
  output logic [AW-1:0]            addr_o,
  input  logic [CH*PSUM_WIDTH-1:0] data_i,
  output logic [DW-1:0]            data_o,
  output logic                     data_o_valid,
  input  logic                     data_o_ready,
  output logic [CH-1:0]            guard_o,
  output logic                     guard_o_valid,
  input  logic                     guard_o_ready
);
  import diff_demo_pkg::*;

  localparam int unsigned IW = (CH > 1) ? $clog2(CH) : 1;
  localparam int unsigned NW = DW / 2;

  wb_state_t              state;
  logic [AW-1:0]          stop_q;
  logic                   diff_q;
  logic                   pass_q;
  logic [CH-1:0][DW-1:0]  v_q;
  logic [CH-1:0]          pend_q;
  logic [CH-1:0]          em_q;

  logic [CH-1:0][DW-1:0]  v_c;
  logic [CH-1:0][DW-1:0]  v_src_c;
  logic [CH-1:0]          guard_c;
  logic [CH-1:0]          mask_c;
  logic [CH-1:0]          clr1_c;
  logic [CH-1:0]          em_c;
  logic [IW-1:0]          idx1_c;
  logic [IW-1:0]          idx2_c;
  logic                   found1_c;
  logic                   found2_c;
  logic [DW-1:0]          byte_c;
  logic                   nibble_mode_c;
  logic                   data_hs_c;
  logic                   guard_hs_c;
  logic                   emit_done_c;

  // ReLU and reduction of each channel to DW bits.
  always_comb begin
    for (int unsigned i = 0; i < CH; i++) begin
      v_c[i] = '0;
      if (!data_i[i*PSUM_WIDTH + PSUM_WIDTH - 1]) begin
`ifdef WB_SATURATE_EN
        if (|data_i[i*PSUM_WIDTH + DW +: PSUM_WIDTH - 1 - DW]) begin
          v_c[i] = '1;
        end else begin
          v_c[i] = data_i[i*PSUM_WIDTH +: DW];
        end
`else
        v_c[i] = data_i[i*PSUM_WIDTH +: DW];
`endif
      end
    end
  end

  // Guard: which channels this pass emits.
  always_comb begin
    guard_c = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      if (!diff_q) begin
        guard_c[i] = |v_c[i];
      end else if (!pass_q) begin
        guard_c[i] = |v_c[i][DW-1:NW];
      end else begin
        guard_c[i] = (|v_c[i][NW-1:0]) && !(|v_c[i][DW-1:NW]);
      end
    end
  end

  assign nibble_mode_c = diff_q & pass_q;
  assign data_hs_c     = data_o_valid & data_o_ready;
  assign guard_hs_c    = guard_o_valid & guard_o_ready;

  // Pending set for the next cycle: fresh guard on load, else minus what
  // was just accepted on the data side.
  always_comb begin
    if (state == WB_LOAD) begin
      mask_c  = guard_c;
      v_src_c = v_c;
    end else begin
      mask_c  = pend_q & ~(em_q & {CH{data_hs_c}});
      v_src_c = v_q;
    end
  end

  wb_pick_first #(.N(CH), .IW(IW)) u_pick_hi (
    .mask    (mask_c),
    .idx_c   (idx1_c),
    .found_c (found1_c)
  );

  assign clr1_c = mask_c & ~(CH'(found1_c) << idx1_c);

  wb_pick_first #(.N(CH), .IW(IW)) u_pick_lo (
    .mask    (clr1_c),
    .idx_c   (idx2_c),
    .found_c (found2_c)
  );

  // Next output byte and the channels it consumes.
  always_comb begin
    byte_c = '0;
    em_c   = '0;
    if (found1_c) begin
      em_c = CH'(1) << idx1_c;
      if (nibble_mode_c) begin
        byte_c[DW-1:NW] = v_src_c[idx1_c][NW-1:0];
      end else begin
        byte_c = v_src_c[idx1_c];
      end
    end
    if (nibble_mode_c && found2_c) begin
      em_c           = em_c | (CH'(1) << idx2_c);
      byte_c[NW-1:0] = v_src_c[idx2_c][NW-1:0];
    end
  end

  // Address finished once nothing is pending and the guard is (being) taken.
  assign emit_done_c = (mask_c == '0) && (!guard_o_valid || guard_o_ready);

  // Control FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= WB_IDLE;
      ctrl_ready    <= 1'b1;
      ctrl_finish   <= 1'b0;
      rd_en         <= 1'b0;
      addr_o        <= '0;
      data_o        <= '0;
      data_o_valid  <= 1'b0;
      guard_o       <= '0;
      guard_o_valid <= 1'b0;
      stop_q        <= '0;
      diff_q        <= 1'b0;
      pass_q        <= 1'b0;
      v_q           <= '0;
      pend_q        <= '0;
      em_q          <= '0;
    end else begin
      ctrl_finish <= 1'b0;
      rd_en       <= 1'b0;
      unique case (state)
        WB_IDLE: begin
          if (ctrl_valid) begin
            stop_q     <= stop_addr_i;
            diff_q     <= is_diff_i;
            pass_q     <= 1'b0;
            addr_o     <= '0;
            rd_en      <= 1'b1;
            ctrl_ready <= 1'b0;
            state      <= WB_FETCH;
          end
        end
        WB_FETCH: begin
          state <= WB_LOAD;
        end
        WB_LOAD: begin
          v_q           <= v_c;
          pend_q        <= mask_c;
          em_q          <= em_c;
          data_o        <= byte_c;
          data_o_valid  <= |mask_c;
          guard_o       <= guard_c;
          guard_o_valid <= 1'b1;
          state         <= WB_EMIT;
        end
        WB_EMIT: begin
          pend_q       <= mask_c;
          em_q         <= em_c;
          data_o       <= byte_c;
          data_o_valid <= |mask_c;
          if (guard_hs_c) begin
            guard_o_valid <= 1'b0;
          end
          if (emit_done_c) begin
            if (addr_o != stop_q) begin
              addr_o <= addr_o + AW'(1);
              rd_en  <= 1'b1;
              state  <= WB_FETCH;
            end else if (diff_q && !pass_q) begin
              pass_q <= 1'b1;
              addr_o <= '0;
              rd_en  <= 1'b1;
              state  <= WB_FETCH;
            end else begin
              ctrl_finish <= 1'b1;
              state       <= WB_DONE;
            end
          end
        end
        WB_DONE: begin
          ctrl_ready <= 1'b1;
          state      <= WB_IDLE;
        end
        default: begin
          state <= WB_IDLE;
        end
      endcase
    end
  end

endmodule
